uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  Transmit stage feeding the UART receiver. Accepts one byte per valid/ready handshake.
//  Builds the 11-bit frame {stop=1, even parity, data[7:0], start=0}.
//  Serialises the frame on tx_line, LSB (start bit) first, at CLKS_PER_BIT clocks per bit.
//  Also presents the frame in parallel on out_tx, with inrx as the receiver's qualify strobe.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; legal range 2..65535
//  CNT_W         16  width of the baud counter; must satisfy 2**CNT_W > CLKS_PER_BIT
// PORTS
//  clk       in   1   single clock; all logic on posedge
//  reset     in   1   synchronous, active-high
//  tx_data   in   8   byte to send; sampled on handshake
//  tx_valid  in   1   byte available
//  tx_ready  out  1   block can accept a byte this cycle
//  tx_line   out  1   serial output; idles high
//  out_tx    out  11  parallel frame: [0]=start, [8:1]=data, [9]=^data, [10]=stop
//  inrx      out  1   high while a frame is being shifted (START..STOP states)
//  busy      out  1   high from the cycle after accept until the last STOP clock ends
// BEHAVIOUR
//  Reset values (sync, active-high): tx_line=1, tx_ready=1, out_tx=11'h400, inrx=0, busy=0.
//  Reset internal state: state=IDLE, baud counter=0, bit index=0.
//  Reset mid-frame aborts the frame. tx_line returns high on the next edge; no partial stop bit.
//  Handshake: a byte transfers when tx_valid && tx_ready are both high on a posedge.
//    tx_valid may be held; there is no combinational path from tx_valid to tx_ready.
//  FSM states and transitions:
//    IDLE   -> START   on handshake; load frame register; clear baud counter and bit index
//    START  -> DATA    after CLKS_PER_BIT clocks; tx_line=0 throughout
//    DATA   -> PARITY  after 8 bits; tx_line=frame[idx+1]; idx increments when the counter wraps
//    PARITY -> STOP    after CLKS_PER_BIT clocks; tx_line=frame[9]
//    STOP   -> IDLE    after CLKS_PER_BIT clocks; tx_line=1
//  Timing:
//    Handshake at edge N: tx_line=0 from cycle N+1.
//    Frame occupies exactly 11*CLKS_PER_BIT cycles.
//    tx_ready re-asserts in the first IDLE cycle, so back-to-back frames have 0 idle bit times.
//  Baud counter:
//    Counts 0..CLKS_PER_BIT-1; wraps to 0 and advances the bit on reaching CLKS_PER_BIT-1.
//    Counter is not free-running; it clears on accept.
//  out_tx updates only on accept and holds its value through IDLE until the next accept.
//  Parity is even: frame[9] = ^tx_data.
//  tx_data changing after accept has no effect on the frame in progress.
//  tx_valid asserted while busy (without the hold feature) stalls with tx_ready=0; no byte is lost.
// CONFIGURATION
//  UART_TX_HOLD_EN defined:
//    Adds a one-entry holding register.
//    tx_ready = !hold_full, so a second byte is accepted during a frame.
//    The held byte launches START on the clock after STOP ends (IDLE lasts 1 cycle).
//    Accepting while hold_full=0 in IDLE bypasses the hold register and goes straight to START.
//  UART_TX_HOLD_EN undefined:
//    tx_ready = (state==IDLE); no holding register.
// STRUCTURE
//  Package uart_pkg:
//    FSM state localparams IDLE/START/DATA/PARITY/STOP (3-bit encoding)
//    FRAME_W=11, DATA_W=8
//    function build_frame(data) returning {1'b1, ^data, data, 1'b0}
//  Sub-module uart_baud_gen (CLKS_PER_BIT, CNT_W):
//    inputs clk, reset, clr
//    output bit_done, a one-clock pulse at count CLKS_PER_BIT-1
//  The receiver side reuses uart_pkg unchanged.
// TESTING (CLKS_PER_BIT=4)
//  1 Reset asserted mid-DATA:
//    next edge: tx_line=1, tx_ready=1, busy=0, out_tx=0x400.
//  2 Send 0xA5:
//    out_tx=0x54A.
//    tx_line sequence, 4 clocks each: 0,1,0,1,0,0,1,0,1,0,1.
//    busy high for 44 cycles.
//  3 Send 0x07:
//    out_tx=0x60E; parity bit=1 on tx_line during clocks 37..40 after accept.
//  4 Hold tx_valid with 0x00 then 0xFF back-to-back, hold feature off:
//    tx_ready low for 44 cycles.
//    Second START begins 1 cycle after the first STOP.
//    Frames read 0x400 then 0x5FE.
//  5 Hold feature on, second byte offered in mid-frame:
//    accepted immediately.
//    Third byte stalls until the first frame ends.
//    No byte dropped or duplicated (scoreboard vs loopback into the receiver).
//  6 Change tx_data during a frame:
//    transmitted bits and out_tx are unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame widths, FSM state encoding and frame builder
package uart_pkg;
  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data);
    return {1'b1, ^data, data, 1'b0};
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter pulsing bit_done on the last clock of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign bit_done = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  // count up and wrap at the end of each bit; held at zero while cleared
  always_comb cnt_d = (clr || bit_done) ? '0 : cnt_q + CNT_W'(1);
  // counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8E1 UART transmitter with parallel frame view; UART_TX_HOLD_EN adds a one-byte holding register
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_line,
  output logic [FRAME_W-1:0] out_tx,
  output logic               inrx,
  output logic               busy
);
  uart_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [2:0]         idx_q, idx_d;
  logic [DATA_W-1:0]  launch_data;
  logic               accept, launch, bit_done;
  assign accept = tx_valid && tx_ready;
`ifdef UART_TX_HOLD_EN
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  assign tx_ready    = !hold_full_q;
  assign launch      = (state_q == IDLE) && (hold_full_q || accept);
  assign launch_data = hold_full_q ? hold_q : tx_data;
  // a byte accepted mid-frame parks here until it launches from IDLE
  always_comb begin
    hold_full_d = (accept && state_q != IDLE) ? 1'b1 : (launch ? 1'b0 : hold_full_q);
    hold_d      = (accept && state_q != IDLE) ? tx_data : hold_q;
  end
  // holding register
  always_ff @(posedge clk) begin
    hold_full_q <= reset ? 1'b0 : hold_full_d;
    hold_q      <= reset ? '0 : hold_d;
  end
`else
  assign tx_ready    = state_q == IDLE;
  assign launch      = accept;
  assign launch_data = tx_data;
`endif
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == IDLE),
    .bit_done(bit_done)
  );
  // next state: advance one frame field per completed bit period
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = launch ? build_frame(launch_data) : frame_q;
    case (state_q)
      IDLE:    if (launch) begin
        state_d = START;
        idx_d   = '0;
      end
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done) begin
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? PARITY : DATA;
      end
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, frame and bit index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= build_frame('0);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end
  assign tx_line = (state_q == START)  ? 1'b0 :
                   (state_q == DATA)   ? frame_q[{1'b0, idx_q} + 4'd1] :
                   (state_q == PARITY) ? frame_q[9] : 1'b1;
  assign out_tx  = frame_q;
  assign busy    = state_q != IDLE;
  assign inrx    = state_q != IDLE;
endmodule
